te_branch_map: RTL and testbench
================================

Name: te_branch_map

Overview:
- Downstream neighbour of the multiple-retirement serializer; consumes its one-instruction-per-cycle stream (iretire/itype/iaddr).
- Records the outcome of each retired conditional branch into an E-trace branch map.
  - Bit value 1 = not taken.
  - Bit value 0 = taken.
- Exposes map and count to the trace-encoder packet emitter, which clears the map when it emits a packet.
- Back-pressures the serializer when the map is full.

Parameters:
- MaxBranches, 31, capacity of the branch map in bits (E-trace maximum); legal range 1..31.
- ItypeLen, 3, width of the itype field (matches mure_pkg::ITYPE_LEN).
- CntLen, $clog2(MaxBranches+1), width of the branch count.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  serializer presents an instruction this cycle.
- ready_o  out  1  block accepts the instruction; transfer = valid_i & ready_o.
- iretire_i  in  1  instruction actually retired; when 0 the beat is consumed but ignored.
- itype_i  in  ItypeLen  E-trace itype; 4 = branch not taken, 5 = branch taken; all other codes are non-branch.
- flush_i  in  1  packet emitter consumed the map; clear on this edge.
- map_o  out  MaxBranches  branch map; bit k = k-th recorded branch, LSB first.
- count_o  out  CntLen  number of valid bits in map_o.
- full_o  out  1  count_o == MaxBranches.
- branch_o  out  1  one-cycle pulse: a branch was recorded on the previous edge.

Behaviour:
- Reset values:
  - map_o = 0, count_o = 0, full_o = 0, branch_o = 0.
  - ready_o = 1 (combinational, see below).
- Branch beat definition: a transfer with iretire_i = 1 and itype_i in {4, 5}. Every other transfer is accepted with no state change.
- Recording: on a branch beat with count = n (n < MaxBranches):
  - map[n] <= (itype_i == 4).
  - count <= n + 1.
  - branch_o <= 1.
  - Latency is one cycle: map_o and count_o reflect the beat on the next cycle.
- Bit hygiene: map bits at index >= count_o are always 0.
- ready_o = !full_o | flush_i (combinational). When full and not flushing, valid_i is stalled.
  - Serializer inputs must be held stable while stalled.
- State machine, states derived from count:
  - EMPTY (count = 0):
    - branch beat -> PARTIAL.
    - If MaxBranches = 1, a branch beat goes directly to FULL.
  - PARTIAL (0 < count < MaxBranches):
    - branch beat -> PARTIAL, or FULL when count reaches MaxBranches.
    - flush -> EMPTY.
  - FULL (count = MaxBranches):
    - only flush leaves this state: -> EMPTY.
    - Input stalls here.
- flush_i with no branch beat: map <= 0, count <= 0. This holds in any state, including EMPTY, where it has no effect.
- Simultaneous flush_i and branch beat: the flush applies first, then the beat is recorded into the cleared map.
  - Result: map = {0.., bit0 = outcome}, count = 1, branch_o = 1.
  - This holds in FULL too; ready_o is high via flush_i.
- flush_i with a non-branch transfer: clear only.
- Wrap-around: none. The count saturates at MaxBranches by stalling and never overflows.
- Reset mid-operation: immediate asynchronous return to reset values. Partial maps are discarded.

Optional Feature:
- Macro: TE_BRANCH_MAP_STATS_EN.
- Compiled in:
  - Adds outputs taken_cnt_o[31:0] and nottaken_cnt_o[31:0].
  - Each counter increments by 1 on every recorded taken / not-taken branch.
  - Counters are unaffected by flush_i and reset to 0 only on rst_ni.
  - Counters wrap from 0xFFFFFFFF to 0 without flagging.
- Compiled out: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, valid_i = 0 for 5 cycles:
  - map_o = 0, count_o = 0, full_o = 0, ready_o = 1, branch_o = 0 throughout.
- Beats itype 5, 4, 4, 5, all iretire = 1:
  - after 4 edges: count_o = 4, map_o = 0b0110.
  - branch_o high in the cycle after each beat.
- Beats itype 4 with iretire = 0, then itype 2, then itype 0, all with valid_i:
  - count_o stays 0, map_o = 0, branch_o never asserts.
- 31 consecutive itype 4 beats:
  - count_o = 31, map_o = 0x7FFFFFFF, full_o = 1, ready_o = 0.
  - A 32nd beat is held stalled and no state changes for 3 cycles.
  - Then flush_i = 1 with the held itype 5 beat: next cycle count_o = 1, map_o = 0, full_o = 0.
- count_o = 7, then flush_i alone:
  - next cycle count_o = 0, map_o = 0.
- rst_ni pulsed low asynchronously mid-cycle with count_o = 12:
  - outputs go to 0 immediately without waiting for a clock edge.
- With TE_BRANCH_MAP_STATS_EN:
  - 3 taken + 2 not-taken beats, a flush, then 1 taken beat.
  - Result: taken_cnt_o = 4, nottaken_cnt_o = 2.

Source files
------------

// File: rtl/te_branch_map.sv
// E-trace branch map: records taken/not-taken outcomes of retired conditional branches.
// Optional statistics counters compiled in with `define TE_BRANCH_MAP_STATS_EN.
module te_branch_map #(
    parameter int unsigned MaxBranches = 31,
    parameter int unsigned ItypeLen    = 3,
    parameter int unsigned CntLen      = $clog2(MaxBranches + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   iretire_i,
    input  logic [ItypeLen-1:0]    itype_i,
    input  logic                   flush_i,
    output logic [MaxBranches-1:0] map_o,
    output logic [CntLen-1:0]      count_o,
    output logic                   full_o,
    output logic                   branch_o
`ifdef TE_BRANCH_MAP_STATS_EN
    ,
    output logic [31:0]            taken_cnt_o,
    output logic [31:0]            nottaken_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_e;

    localparam logic [ItypeLen-1:0] ItypeNotTaken = ItypeLen'(4);
    localparam logic [ItypeLen-1:0] ItypeTaken    = ItypeLen'(5);

    state_e                 state_q, state_d;
    logic [MaxBranches-1:0] map_q, map_d;
    logic [CntLen-1:0]      count_q, count_d;
    logic                   branch_q, branch_d;

    logic xfer;
    logic is_branch;
    logic not_taken;

    assign ready_o   = (state_q != FULL) | flush_i;
    assign xfer      = valid_i & ready_o;
    assign not_taken = (itype_i == ItypeNotTaken);
    assign is_branch = xfer & iretire_i & (not_taken | (itype_i == ItypeTaken));

    // Flush clears first so a coincident branch beat lands in bit 0 of the fresh map.
    always_comb begin
        state_d  = state_q;
        map_d    = map_q;
        count_d  = count_q;
        branch_d = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
            map_d   = '0;
            count_d = '0;
        end
        if (is_branch) begin
            map_d[count_d] = not_taken;
            count_d        = count_d + CntLen'(1);
            branch_d       = 1'b1;
            state_d        = (count_d == CntLen'(MaxBranches)) ? FULL : PARTIAL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= EMPTY;
            map_q    <= '0;
            count_q  <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            map_q    <= map_d;
            count_q  <= count_d;
            branch_q <= branch_d;
        end
    end

    assign map_o    = map_q;
    assign count_o  = count_q;
    assign full_o   = (state_q == FULL);
    assign branch_o = branch_q;

`ifdef TE_BRANCH_MAP_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] nottaken_cnt_q, nottaken_cnt_d;

    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        if (is_branch) begin
            if (not_taken) nottaken_cnt_d = nottaken_cnt_q + 32'd1;
            else           taken_cnt_d    = taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    assign taken_cnt_o    = taken_cnt_q;
    assign nottaken_cnt_o = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_te_branch_map.sv
// Directed self-checking bench for te_branch_map with default parameters (31-bit map).
module tb_te_branch_map;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic        iretire_i;
    logic [2:0]  itype_i;
    logic        flush_i;
    logic [30:0] map_o;
    logic [4:0]  count_o;
    logic        full_o;
    logic        branch_o;
`ifdef TE_BRANCH_MAP_STATS_EN
    logic [31:0] taken_cnt_o;
    logic [31:0] nottaken_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    te_branch_map dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .iretire_i (iretire_i),
        .itype_i   (itype_i),
        .flush_i   (flush_i),
        .map_o     (map_o),
        .count_o   (count_o),
        .full_o    (full_o),
        .branch_o  (branch_o)
`ifdef TE_BRANCH_MAP_STATS_EN
        ,
        .taken_cnt_o    (taken_cnt_o),
        .nottaken_cnt_o (nottaken_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [2:0] it);
        valid_i   = 1'b1;
        iretire_i = 1'b1;
        itype_i   = it;
        tick();
    endtask

    initial begin
        logic [2:0] seq4 [4];
        logic [2:0] seq6 [6];
        seq4 = '{3'd5, 3'd4, 3'd4, 3'd5};
        seq6 = '{3'd4, 3'd5, 3'd4, 3'd4, 3'd5, 3'd5};

        rst_ni = 1'b0; valid_i = 1'b0; iretire_i = 1'b0; itype_i = '0; flush_i = 1'b0;
        #12 rst_ni = 1'b1;

        // reset then idle
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_map", map_o, 0);
            chk("idle_count", count_o, 0);
            chk("idle_full", full_o, 0);
            chk("idle_ready", ready_o, 1);
            chk("idle_branch", branch_o, 0);
        end

        // 5,4,4,5 -> map 0b0110
        for (int i = 0; i < 4; i++) begin
            beat(seq4[i]);
            chk("seq4_branch", branch_o, 1);
            chk("seq4_count", count_o, i + 1);
        end
        chk("seq4_map", map_o, 32'h6);
        valid_i = 1'b0;
        tick();
        chk("seq4_branch_drop", branch_o, 0);

        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush4_count", count_o, 0);
        chk("flush4_map", map_o, 0);

        // non-branch beats
        valid_i = 1'b1; iretire_i = 1'b0; itype_i = 3'd4;
        tick();
        chk("noret_count", count_o, 0);
        chk("noret_branch", branch_o, 0);
        iretire_i = 1'b1; itype_i = 3'd2;
        tick();
        chk("it2_count", count_o, 0);
        chk("it2_branch", branch_o, 0);
        itype_i = 3'd0;
        tick();
        chk("it0_count", count_o, 0);
        chk("it0_map", map_o, 0);
        chk("it0_branch", branch_o, 0);

        // fill to 31
        for (int i = 0; i < 31; i++) beat(3'd4);
        chk("full_count", count_o, 31);
        chk("full_map", map_o, 32'h7FFF_FFFF);
        chk("full_full", full_o, 1);
        chk("full_ready", ready_o, 0);
        itype_i = 3'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_count", count_o, 31);
            chk("stall_map", map_o, 32'h7FFF_FFFF);
            chk("stall_branch", branch_o, 0);
            chk("stall_ready", ready_o, 0);
        end
        flush_i = 1'b1;
        #1;
        chk("flushfull_ready", ready_o, 1);
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flushbeat_count", count_o, 1);
        chk("flushbeat_map", map_o, 0);
        chk("flushbeat_full", full_o, 0);
        chk("flushbeat_branch", branch_o, 1);

        // grow to 7, then flush alone
        for (int i = 0; i < 6; i++) beat(seq6[i]);
        valid_i = 1'b0;
        chk("seven_count", count_o, 7);
        chk("seven_map", map_o, 32'h1A);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush7_count", count_o, 0);
        chk("flush7_map", map_o, 0);

        // async reset with count 12
        for (int i = 0; i < 12; i++) beat(3'd4);
        valid_i = 1'b0;
        chk("twelve_count", count_o, 12);
        chk("twelve_map", map_o, 32'hFFF);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_count", count_o, 0);
        chk("arst_map", map_o, 0);
        chk("arst_full", full_o, 0);
        chk("arst_branch", branch_o, 0);
        chk("arst_ready", ready_o, 1);
        #3 rst_ni = 1'b1;
        tick();

`ifdef TE_BRANCH_MAP_STATS_EN
        chk("stats_rst_taken", taken_cnt_o, 0);
        chk("stats_rst_nottaken", nottaken_cnt_o, 0);
        beat(3'd5); beat(3'd4); beat(3'd5); beat(3'd4); beat(3'd5);
        valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("stats_flush_taken", taken_cnt_o, 3);
        chk("stats_flush_nottaken", nottaken_cnt_o, 2);
        beat(3'd5);
        valid_i = 1'b0;
        chk("stats_taken", taken_cnt_o, 4);
        chk("stats_nottaken", nottaken_cnt_o, 2);
        chk("stats_count", count_o, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
